// File: rtl/inverse_pkg.sv
`default_nettype none
// ============================================================================
// inverse_pkg : command codes and FSM encoding for the inverse sequencer
// Rev 1.0
// ============================================================================
package inverse_pkg;

  localparam logic [5:0] CMD_NOP = 6'h00;
  localparam logic [5:0] CMD_SQR = 6'h01;
  localparam logic [5:0] CMD_MUL = 6'h02;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SQR    = 3'd1,
    ST_MUL    = 3'd2,
    ST_SWAP   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  function automatic logic [5:0] cmd_for(input state_e s);
    case (s)
      ST_SQR:  return CMD_SQR;
      ST_MUL:  return CMD_MUL;
      default: return CMD_NOP;
    endcase
  endfunction

  function automatic logic is_busy(input state_e s);
    return (s == ST_SQR) || (s == ST_MUL) || (s == ST_SWAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inverse_op_timer.sv
`default_nettype none
// ============================================================================
// inverse_op_timer : clearable up-counter flagging the last cycle of an op
// Rev 1.0
// ============================================================================
module inverse_op_timer #(
  parameter int Op_latency = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic last_o
);

  localparam int CW = (Op_latency > 1) ? $clog2(Op_latency) : 1;

  logic [CW-1:0] count_q;

  // Saturates on last so an idle timer never wraps back into a valid count.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (!last_o) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign last_o = (count_q == CW'(Op_latency - 1));

endmodule
`default_nettype wire

// File: rtl/inverse_sequencer.sv
`default_nettype none
// ============================================================================
// inverse_sequencer : steps the field-inverse datapath through square/multiply
// rounds, drives the bank-swap select and gates host RAM writes. Rev 1.0
// ============================================================================
module inverse_sequencer
  import inverse_pkg::*;
#(
  parameter int Command_len = 6,
  parameter int Round_width = 9,
  parameter int Op_latency  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [Round_width-1:0] rounds,
  input  logic                   abort,
  input  logic                   host_wr_en,
  output logic                   wr_en,
  output logic [Command_len-1:0] command,
  output logic                   swap_bus,
  output logic                   busy,
  output logic                   done,
  output logic [Round_width-1:0] round_count,
  output logic                   wr_blocked
);

  state_e                 state_q, state_d;
  logic [Round_width-1:0] rounds_q, rounds_d;
  logic [Round_width-1:0] count_q, count_d;
  logic [Round_width-1:0] count_inc;
  logic                   swap_q, swap_d;
  logic [Command_len-1:0] command_q;
  logic                   busy_q, done_q, wr_blocked_q;
  logic                   op_last;

  inverse_op_timer #(
    .Op_latency (Op_latency)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_d != state_q),
    .last_o (op_last)
  );

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rounds_d = rounds_q;
    count_d  = count_q;
    swap_d   = swap_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          rounds_d = rounds;
          count_d  = '0;
          swap_d   = 1'b0;
          state_d  = (rounds == '0) ? ST_FINISH : ST_SQR;
        end
      end
      ST_SQR: begin
        if (abort)        state_d = ST_IDLE;
        else if (op_last) state_d = ST_MUL;
      end
      ST_MUL: begin
        if (abort)        state_d = ST_IDLE;
        else if (op_last) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        // An abort here leaves the bank mapping and count as they were.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          count_d = count_inc;
          swap_d  = ~swap_q;
          state_d = (count_inc == rounds_q) ? ST_FINISH : ST_SQR;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rounds_q     <= '0;
      count_q      <= '0;
      swap_q       <= 1'b0;
      command_q    <= Command_len'(CMD_NOP);
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_blocked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rounds_q     <= rounds_d;
      count_q      <= count_d;
      swap_q       <= swap_d;
      command_q    <= Command_len'(cmd_for(state_d));
      busy_q       <= is_busy(state_d);
      done_q       <= (state_d == ST_FINISH);
      wr_blocked_q <= host_wr_en & busy_q;
    end
  end

  assign wr_en       = host_wr_en & ~busy_q;
  assign command     = command_q;
  assign swap_bus    = swap_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign round_count = count_q;
  assign wr_blocked  = wr_blocked_q;

endmodule
`default_nettype wire

// File: tb/tb_inverse_sequencer.sv
`default_nettype none
// ============================================================================
// tb_inverse_sequencer : cycle-accurate check of the sequencer against a
// timeline model derived from the round arithmetic. Rev 1.0
// ============================================================================
module tb_inverse_sequencer;

  localparam int LAT = 4;
  localparam int RW  = 9;
  localparam int P   = 2 * LAT + 1;

  logic          clk = 1'b0;
  logic          rst, start, abort, host_wr_en;
  logic [RW-1:0] rounds;
  logic          wr_en, swap_bus, busy, done, wr_blocked;
  logic [5:0]    command;
  logic [RW-1:0] round_count;

  int n_assert = 0;
  int n_fail   = 0;
  int last_cnt = 0;
  bit prev_host = 1'b0;
  bit prev_busy = 1'b0;

  inverse_sequencer #(
    .Command_len (6),
    .Round_width (RW),
    .Op_latency  (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rounds      (rounds),
    .abort       (abort),
    .host_wr_en  (host_wr_en),
    .wr_en       (wr_en),
    .command     (command),
    .swap_bus    (swap_bus),
    .busy        (busy),
    .done        (done),
    .round_count (round_count),
    .wr_blocked  (wr_blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One start at t=0, then cycle-by-cycle comparison against the timeline:
  // round k occupies cycles 1+k*P .. (k+1)*P, done lands at 1+R*P.
  task automatic run(input int R, input int abort_at, input int rst_at, input bit spur);
    int total, stop_t, p, e_cnt, e_cmd;
    bit e_busy, e_done, e_blk, h;
    total  = (R == 0) ? 1 : R * P + 1;
    stop_t = (abort_at >= 0) ? abort_at + 1 : (rst_at >= 0) ? rst_at + 1 : total + 1;
    for (int t = 0; t <= stop_t; t++) begin
      h          = 1'($urandom_range(0, 1));
      rst        = (t == rst_at);
      start      = (t == 0) || (spur && t == 3 && t < stop_t && t < total);
      rounds     = (t == 0) ? RW'(R) : RW'($urandom);
      abort      = (t == abort_at);
      host_wr_en = h;
      #3;
      e_cmd = 0; e_busy = 1'b0; e_done = 1'b0;
      if (rst_at >= 0 && t > rst_at)            e_cnt = 0;
      else if (t == 0 || (abort_at == 0))       e_cnt = last_cnt;
      else if (abort_at > 0 && t > abort_at)    e_cnt = (abort_at - 1) / P;
      else if (R > 0 && t <= R * P) begin
        p      = (t - 1) % P;
        e_cmd  = (p < LAT) ? 1 : (p < 2 * LAT) ? 2 : 0;
        e_busy = 1'b1;
        e_cnt  = (t - 1) / P;
      end else begin
        e_cnt  = R;
        e_done = (t == total);
      end
      e_blk = (rst_at >= 0 && t == rst_at + 1) ? 1'b0 : (prev_host & prev_busy);
      chk("command",     32'(command),     32'(e_cmd));
      chk("busy",        32'(busy),        32'(e_busy));
      chk("done",        32'(done),        32'(e_done));
      chk("round_count", 32'(round_count), 32'(e_cnt));
      chk("swap_bus",    32'(swap_bus),    32'(e_cnt % 2));
      chk("wr_en",       32'(wr_en),       32'(h & ~e_busy));
      chk("wr_blocked",  32'(wr_blocked),  32'(e_blk));
      prev_host = h;
      prev_busy = e_busy;
      last_cnt  = e_cnt;
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int R, ab;
    rst = 1'b1; start = 1'b0; abort = 1'b0; host_wr_en = 1'b0; rounds = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("reset command",     32'(command),     32'h0);
    chk("reset busy",        32'(busy),        32'h0);
    chk("reset done",        32'(done),        32'h0);
    chk("reset round_count", 32'(round_count), 32'h0);
    chk("reset swap_bus",    32'(swap_bus),    32'h0);
    chk("reset wr_blocked",  32'(wr_blocked),  32'h0);
    @(posedge clk); #1;

    run(3, -1, -1, 1'b1);        // single run with an ignored start
    run(0, -1, -1, 1'b0);        // zero rounds
    run(5, 12, -1, 1'b0);        // abort during round 2 squaring
    run(4, 0, -1, 1'b0);         // start and abort together in idle
    run(5, -1, 15, 1'b0);        // reset mid-run
    run(3, -1, -1, 1'b0);        // fresh run after reset
    run(2, 2 * P, -1, 1'b0);     // abort in a swap cycle
    run(1, -1, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      R  = $urandom_range(0, 6);
      ab = (R > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, R * P) : -1;
      run(R, ab, -1, 1'(i % 2));
    end
    run((1 << RW) - 1, -1, -1, 1'b0); // maximum round count, no wrap

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
